// File: rtl/img_pkg.sv
// Shared types for the pixel store path: capture FSM states, pixel layout
// and nibble/pixel widths.
package img_pkg;

    localparam int PIX_W = 12;
    localparam int NIB_W = 4;

    // Bit offsets of the colour fields inside a stored pixel
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        CAP_R,
        CAP_G,
        CAP_B,
        DONE
    } state_t;

    // Field order gives R in [11:8], G in [7:4], B in [3:0]
    typedef struct packed {
        logic [NIB_W-1:0] r;
        logic [NIB_W-1:0] g;
        logic [NIB_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/pack_accept_gen.sv
// Turns the packer's valid into a single-cycle pack accept.
// With PACK_EDGE_DETECT_EN defined only a 0->1 transition of pack_valid_i
// counts; otherwise every high cycle is one pack.
module pack_accept_gen (
    input  logic clk,
    input  logic reset,
    input  logic pack_valid_i,
    output logic accept_o
);

`ifdef PACK_EDGE_DETECT_EN
    logic valid_prev_q;

    // Remember last cycle's valid so a held level is counted only once
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_prev_q <= 1'b0;
        end else begin
            valid_prev_q <= pack_valid_i;
        end
    end

    assign accept_o = pack_valid_i & ~valid_prev_q;
`else
    // Clock and reset are only needed by the edge-detect build
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, reset};

    assign accept_o = pack_valid_i;
`endif

endmodule

// File: rtl/pixel_store_ctrl.sv
// Pixel store controller: gates the upstream bit collector, gathers three
// packs as R, G, B and writes one 12-bit pixel per triple at an incrementing
// address, pulsing frame_done on the last write of a frame.
// Optional build macro: PACK_EDGE_DETECT_EN (see pack_accept_gen).
module pixel_store_ctrl
    import img_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pack_valid,
    input  logic [NIB_W-1:0]  pack_data,
    output logic              rx_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    if ((2 ** ADDR_W) < NPIX) begin : g_addr_check
        $error("pixel_store_ctrl: ADDR_W too small for IMG_W*IMG_H");
    end

    logic accept;

    pack_accept_gen u_accept (
        .clk          (clk),
        .reset        (reset),
        .pack_valid_i (pack_valid),
        .accept_o     (accept)
    );

    state_t             state_q;
    logic               rx_en_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;   // doubles as the pixel counter
    pixel_t             wr_data_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               err_q;
    logic [NIB_W-1:0]   r_q;
    logic [NIB_W-1:0]   g_q;

    // Capture FSM with registered outputs; the address advances once the
    // write strobe has been presented and wraps after the last pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (wr_en_q) begin
                wr_addr_q <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CAP_R;
                        busy_q    <= 1'b1;
                        rx_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        err_q     <= 1'b0;
                    end
                    // A pack here is dropped; it still flags even alongside start
                    if (accept) begin
                        err_q <= 1'b1;
                    end
                end
                CAP_R: begin
                    if (accept) begin
                        r_q     <= pack_data;
                        state_q <= CAP_G;
                    end
                end
                CAP_G: begin
                    if (accept) begin
                        g_q     <= pack_data;
                        state_q <= CAP_B;
                    end
                end
                CAP_B: begin
                    if (accept) begin
                        wr_data_q <= '{r: r_q, g: g_q, b: pack_data};
                        wr_en_q   <= 1'b1;
                        if (wr_addr_q == LAST_ADDR) begin
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                            rx_en_q      <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q <= CAP_R;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (accept) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_en       = rx_en_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_q;

endmodule
